ub_write_arbiter: RTL

- Sequences all writes into the unified buffer through a single registered write port (one 32-bit word per cycle).
- Requesters: accumulator 1 and accumulator 2, each storing a 2-word burst at an auto-incrementing write pointer, plus a host port storing single words at an explicit address (activation preload).
- Round-robin arbitration, pointer management, full detection and pointer rewind live here; the buffer itself is a plain addressed memory.

---
 rtl/ub_write_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ub_write_arbiter.sv
// Unified-buffer write arbiter: round-robin over two accumulator burst
// writers and a host single-word port, with a shared auto-incrementing pointer.
module ub_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int BASE_ADDR  = 0,
    parameter int LIMIT_ADDR = 29
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              acc1_req,
    input  logic [DATA_W-1:0] acc1_data0,
    input  logic [DATA_W-1:0] acc1_data1,
    output logic              acc1_ack,
    input  logic              acc2_req,
    input  logic [DATA_W-1:0] acc2_data0,
    input  logic [DATA_W-1:0] acc2_data1,
    output logic              acc2_ack,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    input  logic              ptr_clear,
    output logic              ub_wr_en,
    output logic [ADDR_W-1:0] ub_wr_addr,
    output logic [DATA_W-1:0] ub_wr_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, ACC_W0, ACC_W1, HOST_W} state_t;
    typedef enum logic [1:0] {G_ACC1, G_ACC2, G_HOST} grant_t;

    state_t state;
    grant_t grant;
    grant_t last_grant;
    grant_t win;
    logic   clear_pending;
    logic   e1, e2, eh, win_valid;
    logic [ADDR_W-1:0] ptr_inc;

    // Extra bit keeps the compare exact when LIMIT_ADDR is the top address.
    function automatic logic is_full(input logic [ADDR_W-1:0] p);
        return ({1'b0, p} + (ADDR_W+1)'(2)) > (ADDR_W+1)'(LIMIT_ADDR + 1);
    endfunction

    assign e1        = acc1_req & ~full;
    assign e2        = acc2_req & ~full;
    assign eh        = host_req;
    assign win_valid = e1 | e2 | eh;
    assign ptr_inc   = wr_ptr + ADDR_W'(1);

    always_comb begin
        win = G_ACC1;
        case (last_grant)
            G_HOST:  win = e1 ? G_ACC1 : (e2 ? G_ACC2 : G_HOST);
            G_ACC1:  win = e2 ? G_ACC2 : (eh ? G_HOST : G_ACC1);
            default: win = eh ? G_HOST : (e1 ? G_ACC1 : G_ACC2);
        endcase
    end

    // ACC_W0/ACC_W1/HOST_W are the cycles in which the registered write is visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            grant         <= G_HOST;
            last_grant    <= G_HOST;
            clear_pending <= 1'b0;
            wr_ptr        <= BASE;
            full          <= is_full(BASE);
            ub_wr_en      <= 1'b0;
            ub_wr_addr    <= '0;
            ub_wr_data    <= '0;
            acc1_ack      <= 1'b0;
            acc2_ack      <= 1'b0;
            host_ack      <= 1'b0;
        end else begin
            ub_wr_en <= 1'b0;
            acc1_ack <= 1'b0;
            acc2_ack <= 1'b0;
            host_ack <= 1'b0;
            if (ptr_clear && state != IDLE) begin
                clear_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clear_pending || ptr_clear) begin
                        wr_ptr        <= BASE;
                        full          <= is_full(BASE);
                        clear_pending <= 1'b0;
                    end else if (win_valid) begin
                        grant      <= win;
                        last_grant <= win;
                        ub_wr_en   <= 1'b1;
                        if (win == G_HOST) begin
                            state      <= HOST_W;
                            ub_wr_addr <= host_addr;
                            ub_wr_data <= host_data;
                            host_ack   <= 1'b1;
                        end else begin
                            state      <= ACC_W0;
                            ub_wr_addr <= wr_ptr;
                            ub_wr_data <= (win == G_ACC2) ? acc2_data0
                                                          : acc1_data0;
                            wr_ptr     <= ptr_inc;
                            full       <= is_full(ptr_inc);
                        end
                    end
                end
                ACC_W0: begin
                    state      <= ACC_W1;
                    ub_wr_en   <= 1'b1;
                    ub_wr_addr <= wr_ptr;
                    ub_wr_data <= (grant == G_ACC2) ? acc2_data1 : acc1_data1;
                    wr_ptr     <= ptr_inc;
                    full       <= is_full(ptr_inc);
                    acc1_ack   <= (grant == G_ACC1);
                    acc2_ack   <= (grant == G_ACC2);
                end
                ACC_W1:  state <= IDLE;
                HOST_W:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
